ed25519_sign_loader: RTL

- Upstream front-end for the ed25519_shake128 signer.
- Accepts one byte-serial frame per signature: 32 seed bytes followed by 0..32 message bytes.
- Assembles the frame into the signer's seed, msg and msg_len inputs, pulses start, then holds those inputs stable until the signer reports done.
- Rejects malformed frames without ever starting the signer.

---
 rtl/ed25519_sign_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ed25519_sign_loader.sv
// Byte-serial frame loader for the ed25519_shake128 signer: packs seed and message, fires start.
// Optional watchdog while waiting for core_done is enabled by defining ED_LOADER_TIMEOUT_EN.
module ed25519_sign_loader #(
    parameter int unsigned SEED_BYTES     = 32,
    parameter int unsigned MAX_MSG_BYTES  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [255:0] seed,
    output logic [255:0] msg,
    output logic [6:0]   msg_len,
    output logic         start,
    input  logic         core_done,
    output logic         frame_err,
    output logic         loader_busy
);

    localparam int unsigned CntW = $clog2(SEED_BYTES + 1);

    typedef enum logic [2:0] {
        StSeed,
        StMsg,
        StDrain,
        StFire,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [255:0]    seed_q, seed_d;
    logic [255:0]    msg_q, msg_d;
    logic [6:0]      msg_len_q, msg_len_d;
    logic [CntW-1:0] seed_cnt_q, seed_cnt_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            accept;
`ifdef ED_LOADER_TIMEOUT_EN
    logic [31:0]     timer_q, timer_d;
`endif

    assign accept = s_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        msg_d      = msg_q;
        msg_len_d  = msg_len_q;
        seed_cnt_d = seed_cnt_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
`ifdef ED_LOADER_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            StSeed: begin
                if (accept) begin
                    // First byte of a frame wipes the previous frame's message.
                    if (seed_cnt_q == '0) begin
                        msg_d     = '0;
                        msg_len_d = '0;
                        busy_d    = 1'b1;
                    end
                    seed_d = {seed_q[247:0], s_data};
                    if (seed_cnt_q == CntW'(SEED_BYTES - 1)) begin
                        seed_cnt_d = '0;
                        state_d    = s_last ? StFire : StMsg;
                    end else if (s_last) begin
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        seed_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
            end
            StMsg: begin
                if (accept) begin
                    if (msg_len_q == 7'(MAX_MSG_BYTES)) begin
                        err_d = 1'b1;
                        if (s_last) begin
                            busy_d  = 1'b0;
                            state_d = StSeed;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        msg_d     = {msg_q[247:0], s_data};
                        msg_len_d = msg_len_q + 7'd1;
                        if (s_last) begin
                            state_d = StFire;
                        end
                    end
                end
            end
            StDrain: begin
                if (accept && s_last) begin
                    busy_d  = 1'b0;
                    state_d = StSeed;
                end
            end
            StFire: begin
                state_d = StWait;
`ifdef ED_LOADER_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            StWait: begin
                if (core_done) begin
                    busy_d  = 1'b0;
                    state_d = StSeed;
                end
`ifdef ED_LOADER_TIMEOUT_EN
                else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StSeed;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
`endif
            end
            default: begin
                state_d = StSeed;
            end
        endcase
        // Registered ready keeps s_ready low through reset and drops it right after the last byte.
        ready_d = (state_d == StSeed) || (state_d == StMsg) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSeed;
            seed_q     <= '0;
            msg_q      <= '0;
            msg_len_q  <= '0;
            seed_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
`ifdef ED_LOADER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            msg_q      <= msg_d;
            msg_len_q  <= msg_len_d;
            seed_cnt_q <= seed_cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
`ifdef ED_LOADER_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign s_ready     = ready_q;
    assign seed        = seed_q;
    assign msg         = msg_q;
    assign msg_len     = msg_len_q;
    assign start       = (state_q == StFire);
    assign frame_err   = err_q;
    assign loader_busy = busy_q;

endmodule
